// File: rtl/encoder_pkg.sv
// Shared constants, state encoding and bit helpers for the sequential 16-to-4 encoder.
package encoder_pkg;

   localparam int WIDTH  = 16;
   localparam int CODE_W = 4;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRAIN = 2'd1,
      S_ZERO  = 2'd2
   } state_e;

   // A word with exactly one bit set clears to zero when its lowest bit is removed.
   function automatic logic is_single_bit(input logic [WIDTH-1:0] word);
      return (word != '0) && ((word & (word - 1'b1)) == '0);
   endfunction

endpackage

// File: rtl/priority_encoder_16to4.sv
// Combinational lowest-set-bit encoder; any flags a nonzero word.
module priority_encoder_16to4
   import encoder_pkg::*;
(
   input  logic [WIDTH-1:0]  word,
   output logic [CODE_W-1:0] code,
   output logic              any
);

   // Scan downward so the lowest set bit is the last one written.
   always_comb begin
      code = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (word[i]) begin
            code = CODE_W'(i);
         end
      end
   end

   assign any = |word;

endmodule

// File: rtl/sixteen_to_four_encoder_seq.sv
// Captures a request word and emits the index of each set bit, lowest first,
// one beat per output handshake; an all-zero word yields a single null beat.
//
// state   | meaning
// S_IDLE  | no word held, ready to capture
// S_DRAIN | emitting codes of the remaining set bits in pending
// S_ZERO  | captured word was zero, presenting one null beat
module sixteen_to_four_encoder_seq #(
   parameter  int WIDTH  = 16,
   localparam int CODE_W = $clog2(WIDTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  in_word,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CODE_W-1:0] out_code,
   output logic              out_last,
   output logic              out_none,
   output logic              busy
);

   import encoder_pkg::*;

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  pending_q, pending_d;
   logic [CODE_W-1:0] enc_code;
   logic              enc_any;
   logic [WIDTH-1:0]  clr_mask;

   priority_encoder_16to4 u_penc (
      .word (pending_q),
      .code (enc_code),
      .any  (enc_any)
   );

   assign clr_mask = WIDTH'(1) << enc_code;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         pending_q <= '0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_code  = '0;
      out_last  = 1'b0;
      out_none  = 1'b0;

      case (state_q)
         S_IDLE: begin
            in_ready = ~rst;
            if (in_valid && !rst) begin
               pending_d = in_word;
               state_d   = (|in_word) ? S_DRAIN : S_ZERO;
            end
         end
         S_DRAIN: begin
            out_valid = 1'b1;
            out_code  = enc_code;
            out_last  = is_single_bit(pending_q);
            if (!enc_any) begin
               state_d = S_IDLE;
            end else if (out_ready) begin
               pending_d = pending_q & ~clr_mask;
               if (out_last) begin
                  state_d = S_IDLE;
               end
            end
         end
         S_ZERO: begin
            out_valid = 1'b1;
            out_none  = 1'b1;
            out_last  = 1'b1;
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d   = S_IDLE;
            pending_d = '0;
         end
      endcase
   end

   assign busy = (state_q != S_IDLE);

endmodule
